muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_signfix.sv | 40 ++++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// divide-by-zero fill constant and small op-classification helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_MADD  = 3'd2,
        MD_MADDU = 3'd3,
        MD_MSUB  = 3'd4,
        MD_MSUBU = 3'd5,
        MD_DIV   = 3'd6,
        MD_DIVU  = 3'd7
    } muldiv_op_e;

    localparam int unsigned MULDIV_STATE_W = 2;
    localparam logic [MULDIV_STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [MULDIV_STATE_W-1:0] ST_CALC = 2'd1;
    localparam logic [MULDIV_STATE_W-1:0] ST_FIX  = 2'd2;
    localparam logic [MULDIV_STATE_W-1:0] ST_DONE = 2'd3;

    // LO value returned on divide-by-zero; sliced to WIDTH by the user
    localparam int unsigned MULDIV_MAX_W = 128;
    localparam logic [MULDIV_MAX_W-1:0] MULDIV_DIVZERO_LO = '1;

    function automatic logic op_is_signed(input muldiv_op_e op);
        return op inside {MD_MULT, MD_MADD, MD_MSUB, MD_DIV};
    endfunction

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final-cycle fixup: restores signs of product/quotient/remainder and applies
// the HI/LO accumulate or subtract for MADD*/MSUB*.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  muldiv_op_e           op_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    input  logic                 neg_res_i,
    input  logic                 neg_dvd_i,
    output logic [2*WIDTH-1:0]   result_c
);

    localparam int unsigned DW = 2 * WIDTH;

    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo_f;
    logic [WIDTH-1:0] rem_f;

    always_comb begin : fix_comb
        prod     = neg_res_i ? (~acc_i + DW'(1)) : acc_i;
        quo      = acc_i[WIDTH-1:0];
        rem      = acc_i[DW-1:WIDTH];
        quo_f    = neg_res_i ? (~quo + WIDTH'(1)) : quo;
        // remainder follows the dividend so division truncates toward zero
        rem_f    = neg_dvd_i ? (~rem + WIDTH'(1)) : rem;
        result_c = prod;
        case (op_i)
            MD_MADD, MD_MADDU: result_c = hilo_i + prod;
            MD_MSUB, MD_MSUBU: result_c = hilo_i - prod;
            MD_DIV,  MD_DIVU:  result_c = {rem_f, quo_f};
            default:           result_c = prod;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply / multiply-accumulate / divide unit for the execute stage:
// one radix-2 iteration per cycle, followed by a single sign-fix cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int unsigned DW = 2 * WIDTH;

    logic [MULDIV_STATE_W-1:0] state_q, state_nxt;
    muldiv_op_e                op_q, op_nxt, op_in;
    logic [WIDTH-1:0]          a_q, a_nxt;
    logic [WIDTH-1:0]          b_q, b_nxt;
    logic                      neg_res_q, neg_res_nxt;
    logic                      neg_dvd_q, neg_dvd_nxt;
    logic [DW-1:0]             hilo_q, hilo_nxt;
    logic [DW-1:0]             acc_q, acc_nxt;
    logic [CNT_W-1:0]          cnt_q, cnt_nxt;
    logic [DW-1:0]             result_nxt;
    logic                      busy_nxt, ready_nxt;

    logic                      in_signed, in_div;
    logic [WIDTH-1:0]          mag1, mag2;
    logic [WIDTH:0]            mul_sum;
    logic [DW-1:0]             mul_step;
    logic [WIDTH:0]            div_shift;
    logic [WIDTH+1:0]          div_diff;
    logic                      div_nb;
    logic [DW-1:0]             div_step;
    logic [DW-1:0]             fix_res;

    assign op_in = muldiv_op_e'(op_i);

    // Request decode: operand magnitudes for signed ops, raw for unsigned
    always_comb begin : in_decode
        in_signed = op_is_signed(op_in);
        in_div    = op_is_div(op_in);
        mag1      = (in_signed && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
        mag2      = (in_signed && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    end

    // One iteration of each algorithm; acc holds {upper, lower} working halves
    always_comb begin : step_comb
        mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : WIDTH'(0))};
        mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = acc_q[DW-1:WIDTH-1];
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_nb    = ~div_diff[WIDTH+1];
        div_step  = {(div_nb ? WIDTH'(div_diff) : WIDTH'(div_shift)), acc_q[WIDTH-2:0], div_nb};
    end

    muldiv_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .hilo_i    (hilo_q),
        .neg_res_i (neg_res_q),
        .neg_dvd_i (neg_dvd_q),
        .result_c  (fix_res)
    );

    // Next-state and datapath update
    always_comb begin : fsm_comb
        state_nxt   = state_q;
        op_nxt      = op_q;
        a_nxt       = a_q;
        b_nxt       = b_q;
        neg_res_nxt = neg_res_q;
        neg_dvd_nxt = neg_dvd_q;
        hilo_nxt    = hilo_q;
        acc_nxt     = acc_q;
        cnt_nxt     = cnt_q;
        result_nxt  = result_o;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    if (in_div && (opdata2_i == '0)) begin
                        state_nxt  = ST_DONE;
                        result_nxt = {opdata1_i, MULDIV_DIVZERO_LO[WIDTH-1:0]};
                    end else begin
                        state_nxt   = ST_CALC;
                        op_nxt      = op_in;
                        a_nxt       = mag1;
                        b_nxt       = mag2;
                        neg_res_nxt = in_signed && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_dvd_nxt = in_signed && opdata1_i[WIDTH-1];
                        hilo_nxt    = hilo_i;
                        cnt_nxt     = '0;
                        // multiplier or dividend starts in the low half
                        acc_nxt     = {WIDTH'(0), (in_div ? mag1 : mag2)};
                    end
                end
            end
            ST_CALC: begin
                if (annul_i) begin
                    state_nxt = ST_IDLE;
                end else begin
                    acc_nxt = op_is_div(op_q) ? div_step : mul_step;
                    cnt_nxt = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_nxt = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (annul_i) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt  = ST_DONE;
                    result_nxt = fix_res;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt  = (state_nxt != ST_IDLE);
        ready_nxt = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= MD_MULT;
            a_q       <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_dvd_q <= 1'b0;
            hilo_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_o    <= 1'b0;
            ready_o   <= 1'b0;
            result_o  <= '0;
        end else begin
            state_q   <= state_nxt;
            op_q      <= op_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            neg_res_q <= neg_res_nxt;
            neg_dvd_q <= neg_dvd_nxt;
            hilo_q    <= hilo_nxt;
            acc_q     <= acc_nxt;
            cnt_q     <= cnt_nxt;
            busy_o    <= busy_nxt;
            ready_o   <= ready_nxt;
            result_o  <= result_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {HI,LO} and latency,
// a negedge monitor pops and compares on every ready_o pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [2:0]      op_i;
    logic [W-1:0]    opdata1_i;
    logic [W-1:0]    opdata2_i;
    logic [2*W-1:0]  hilo_i;
    logic            annul_i;
    logic            busy_o;
    logic            ready_o;
    logic [2*W-1:0]  result_o;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          ready_cnt = 0;
    int          push_cnt  = 0;
    logic [63:0] last_exp  = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .hilo_i    (hilo_i),
        .annul_i   (annul_i),
        .busy_o    (busy_o),
        .ready_o   (ready_o),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on sign/zero-extended operands
    function automatic logic [63:0] ref_model(input muldiv_op_e op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hilo);
        logic signed [63:0] sa, sbv, q, r;
        logic [63:0]        ua, ub, uq, ur;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (op)
            MD_MULT:  return sa * sbv;
            MD_MULTU: return ua * ub;
            MD_MADD:  return hilo + (sa * sbv);
            MD_MADDU: return hilo + (ua * ub);
            MD_MSUB:  return hilo - (sa * sbv);
            MD_MSUBU: return hilo - (ua * ub);
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Drive one start for a cycle; when push is set, record the expected response
    task automatic issue(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] hilo, input bit push,
                         input bit have_exp, input logic [63:0] exp_v);
        exp_t e;
        @(negedge clk);
        start_i   = 1'b1;
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        hilo_i    = hilo;
        if (push) begin
            e.res       = have_exp ? exp_v : ref_model(op, a, b, hilo);
            e.lat       = ((op == MD_DIV || op == MD_DIVU) && b == 32'd0) ? 1 : W + 2;
            e.start_cyc = cyc;
            sb.push_back(e);
            push_cnt++;
            last_exp = e.res;
        end
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: timeout with %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every ready_o pulse must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (rst && ready_o) begin
            ready_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got result %h, expected no ready", result_o);
            end else begin
                e = sb.pop_front();
                chk("result", result_o, e.res);
                chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start_i   = 1'b0;
        op_i      = '0;
        opdata1_i = '0;
        opdata2_i = '0;
        hilo_i    = '0;
        annul_i   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   64'(busy_o),  64'd0);
        chk("reset_ready",  64'(ready_o), 64'd0);
        chk("reset_result", result_o,     64'd0);
        rst = 1'b1;

        // Directed cases with hand-derived results
        issue(MD_MULT,  32'hFFFF_FFFD, 32'd7,         64'd0, 1, 1, 64'hFFFF_FFFF_FFFF_FFEB); wait_done();
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1, 1, 64'hFFFF_FFFE_0000_0001); wait_done();
        issue(MD_MADDU, 32'd2, 32'd3, 64'h0000_0000_FFFF_FFFF, 1, 1, 64'h0000_0001_0000_0005); wait_done();
        issue(MD_MADD,  32'hFFFF_FFFB, 32'd4, 64'd100, 1, 1, 64'd80); wait_done();
        issue(MD_MSUB,  32'hFFFF_FFFE, 32'd3, 64'd0,   1, 1, 64'd6);  wait_done();
        issue(MD_MSUBU, 32'd3, 32'd4, 64'd10, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE); wait_done();
        issue(MD_DIV,   32'hFFFF_FFF9, 32'd2, 64'd0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD); wait_done();
        issue(MD_DIV,   32'd7, 32'hFFFF_FFFE, 64'd0, 1, 1, 64'h0000_0001_FFFF_FFFD); wait_done();
        issue(MD_DIVU,  32'd100, 32'd7, 64'd0, 1, 1, 64'h0000_0002_0000_000E); wait_done();
        issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1, 1, 64'h0000_0000_8000_0000); wait_done();
        issue(MD_DIVU,  32'd5, 32'd0, 64'd0, 1, 1, 64'h0000_0005_FFFF_FFFF); wait_done();
        issue(MD_DIV,   32'hFFFF_FFF0, 32'd0, 64'd0, 1, 1, 64'hFFFF_FFF0_FFFF_FFFF); wait_done();

        // Annul mid-CALC: no ready, busy drops, result retained
        issue(MD_MULT, 32'd5, 32'd6, 64'd0, 0, 0, 64'd0);
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul_busy", 64'(busy_o), 64'd0);
        repeat (40) @(negedge clk);
        chk("annul_result_kept", result_o, last_exp);
        issue(MD_MULT, 32'd2, 32'd2, 64'd0, 1, 1, 64'd4); wait_done();

        // start_i held while busy must be ignored
        issue(MD_DIVU, 32'd1000, 32'd3, 64'd0, 1, 1, 64'h0000_0001_0000_014D);
        start_i   = 1'b1;
        op_i      = MD_MULT;
        opdata1_i = 32'd9;
        opdata2_i = 32'd9;
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-CALC
        issue(MD_MULTU, 32'h1234_5678, 32'd77, 64'd0, 0, 0, 64'd0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset_busy",   64'(busy_o),  64'd0);
        chk("midreset_ready",  64'(ready_o), 64'd0);
        chk("midreset_result", result_o,     64'd0);
        @(negedge clk);
        rst = 1'b1;
        last_exp = '0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            muldiv_op_e  op;
            logic [31:0] a, b;
            logic [63:0] h;
            op = muldiv_op_e'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            h  = {$urandom, $urandom};
            issue(op, a, b, h, 1, 0, 64'd0);
            wait_done();
        end

        repeat (40) @(negedge clk);
        chk("ready_count", 64'(ready_cnt), 64'(push_cnt));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
